cbc_block_sequencer: RTL and testbench

Sequential CBC-mode controller that drives one shared 16-bit block-cipher core (20-bit key) over a 128-bit message, one block at a time. It encrypts or decrypts in place of a fully unrolled chain. It accepts a message, key, IV and mode over a valid/ready handshake. It then issues 8 core operations with chaining XOR and returns the 128-bit result over a valid/ready handshake.

---
 rtl/cbc_block_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cbc_block_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbc_block_sequencer.sv
// CBC-mode sequencer: runs a 128-bit message through one shared 16-bit block
// cipher core, one block at a time, with chaining XOR applied around the core.
module cbc_block_sequencer #(
   parameter int unsigned BLOCK_W    = 16,
   parameter int unsigned NUM_BLOCKS = 8,
   parameter int unsigned KEY_W      = 20,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_decrypt,
   input  logic [BLOCK_W*NUM_BLOCKS-1:0]   in_data,
   input  logic [KEY_W-1:0]                in_key,
   input  logic [BLOCK_W-1:0]              in_iv,
   output logic                            core_start,
   output logic                            core_decrypt,
   output logic [BLOCK_W-1:0]              core_block,
   output logic [KEY_W-1:0]                core_key,
   input  logic                            core_done,
   input  logic [BLOCK_W-1:0]              core_result,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [BLOCK_W*NUM_BLOCKS-1:0]   out_data,
   output logic                            out_error,
   output logic                            busy
);

   localparam int unsigned MSG_W = BLOCK_W * NUM_BLOCKS;
   localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              r_state;
   logic [BLOCK_W-1:0]  r_data [NUM_BLOCKS];
   logic [BLOCK_W-1:0]  r_res  [NUM_BLOCKS];
   logic [KEY_W-1:0]    r_key;
   logic                r_dec;
   logic [BLOCK_W-1:0]  r_chain;
   logic [IDX_W-1:0]    r_idx;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_in_ready;
   logic                r_busy;
   logic                r_core_start;
   logic [BLOCK_W-1:0]  r_core_block;
   logic                r_out_valid;
   logic                r_out_error;

   state_t              w_nxt_state;
   logic [BLOCK_W-1:0]  w_in_blk   [NUM_BLOCKS];
   logic [BLOCK_W-1:0]  w_nxt_data [NUM_BLOCKS];
   logic [BLOCK_W-1:0]  w_nxt_res  [NUM_BLOCKS];
   logic [KEY_W-1:0]    w_nxt_key;
   logic                w_nxt_dec;
   logic [BLOCK_W-1:0]  w_nxt_chain;
   logic [IDX_W-1:0]    w_nxt_idx;
   logic [TMO_W-1:0]    w_nxt_tmo;
   logic                w_nxt_err;
   logic [BLOCK_W-1:0]  w_nxt_blk;
   logic [BLOCK_W-1:0]  w_nxt_core_block;

   // Block 0 sits in the most significant slice of the message bus.
   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk
      assign w_in_blk[g] = in_data[MSG_W-1-g*BLOCK_W -: BLOCK_W];
      assign out_data[MSG_W-1-g*BLOCK_W -: BLOCK_W] = r_res[g];
   end

   assign in_ready     = r_in_ready;
   assign busy         = r_busy;
   assign core_start   = r_core_start;
   assign core_block   = r_core_block;
   assign core_decrypt = r_dec;
   assign core_key     = r_key;
   assign out_valid    = r_out_valid;
   assign out_error    = r_out_error;

   // Next-state and next-output logic; registered outputs are derived from the next state.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_data  = r_data;
      w_nxt_res   = r_res;
      w_nxt_key   = r_key;
      w_nxt_dec   = r_dec;
      w_nxt_chain = r_chain;
      w_nxt_idx   = r_idx;
      w_nxt_tmo   = r_tmo;
      w_nxt_err   = r_out_error;
      case (r_state)
         S_IDLE: begin
            w_nxt_err = 1'b0;
            if (in_valid) begin
               w_nxt_data  = w_in_blk;
               w_nxt_res   = '{default: '0};
               w_nxt_key   = in_key;
               w_nxt_dec   = in_decrypt;
               w_nxt_chain = in_iv;
               w_nxt_idx   = '0;
               w_nxt_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_nxt_tmo   = '0;
            w_nxt_state = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               if (r_dec) begin
                  w_nxt_res[r_idx] = core_result ^ r_chain;
                  w_nxt_chain      = r_data[r_idx];
               end else begin
                  w_nxt_res[r_idx] = core_result;
                  w_nxt_chain      = core_result;
               end
               if (r_idx == IDX_W'(NUM_BLOCKS - 1)) begin
                  w_nxt_state = S_DONE;
               end else begin
                  w_nxt_idx   = r_idx + IDX_W'(1);
                  w_nxt_state = S_ISSUE;
               end
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
               w_nxt_err   = 1'b1;
               w_nxt_state = S_DONE;
            end else begin
               w_nxt_tmo = r_tmo + TMO_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_nxt_err   = 1'b0;
               w_nxt_state = S_IDLE;
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
      w_nxt_blk        = w_nxt_data[w_nxt_idx];
      w_nxt_core_block = '0;
      if (w_nxt_state == S_ISSUE) begin
         w_nxt_core_block = w_nxt_dec ? w_nxt_blk : (w_nxt_blk ^ w_nxt_chain);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_data       <= '{default: '0};
         r_res        <= '{default: '0};
         r_key        <= '0;
         r_dec        <= 1'b0;
         r_chain      <= '0;
         r_idx        <= '0;
         r_tmo        <= '0;
         r_in_ready   <= 1'b1;
         r_busy       <= 1'b0;
         r_core_start <= 1'b0;
         r_core_block <= '0;
         r_out_valid  <= 1'b0;
         r_out_error  <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_data       <= w_nxt_data;
         r_res        <= w_nxt_res;
         r_key        <= w_nxt_key;
         r_dec        <= w_nxt_dec;
         r_chain      <= w_nxt_chain;
         r_idx        <= w_nxt_idx;
         r_tmo        <= w_nxt_tmo;
         r_in_ready   <= (w_nxt_state == S_IDLE);
         r_busy       <= (w_nxt_state != S_IDLE);
         r_core_start <= (w_nxt_state == S_ISSUE);
         r_core_block <= w_nxt_core_block;
         r_out_valid  <= (w_nxt_state == S_DONE);
         r_out_error  <= w_nxt_err;
      end
   end

endmodule

// File: tb/tb_cbc_block_sequencer.sv
// Bench for cbc_block_sequencer: XOR-with-key core stub (3-cycle latency) and a
// scoreboard of expected messages built by a reference CBC model.
module tb_cbc_block_sequencer;

   localparam int NB = 8;
   localparam logic [127:0] ENC1 = 128'h6DD8A63E6DD8A63E6DD8A63E6DD8A63E;
   localparam logic [127:0] PT1  = {32{4'h4}};

   typedef struct packed {
      logic [127:0] data;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_decrypt = 1'b0;
   logic [127:0] in_data = '0;
   logic [19:0]  in_key = '0;
   logic [15:0]  in_iv = '0;
   logic         core_start;
   logic         core_decrypt;
   logic [15:0]  core_block;
   logic [19:0]  core_key;
   logic         core_done;
   logic [15:0]  core_result;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic         out_error;
   logic         busy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // core stub state
   int          stub_cnt = 0;
   int          stub_nstart = 0;
   int          stub_drop = -1;
   logic        stub_done = 1'b0;
   logic [15:0] stub_blk = '0;
   logic [15:0] stub_res = '0;
   logic        spur_done = 1'b0;
   logic [15:0] spur_res = '0;

   assign core_done   = stub_done | spur_done;
   assign core_result = spur_done ? spur_res : stub_res;

   cbc_block_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
      .in_data(in_data), .in_key(in_key), .in_iv(in_iv),
      .core_start(core_start), .core_decrypt(core_decrypt), .core_block(core_block),
      .core_key(core_key), .core_done(core_done), .core_result(core_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_error(out_error), .busy(busy)
   );

   always #5 clk = ~clk;

   // E(x) = D(x) = x ^ key[15:0]; done lands in the 3rd cycle after the start cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         stub_cnt  = 0;
         stub_done = 1'b0;
      end else begin
         stub_done = 1'b0;
         if (stub_cnt != 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               stub_done = 1'b1;
               stub_res  = stub_blk ^ core_key[15:0];
            end
         end
         if (core_start) begin
            if (stub_nstart != stub_drop) begin
               stub_cnt = 3;
               stub_blk = core_block;
            end
            stub_nstart++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   function automatic logic [127:0] cbc_model(input bit dec, input logic [127:0] d,
                                              input logic [19:0] k, input logic [15:0] iv,
                                              input int nok);
      logic [15:0]  ch, b, o;
      logic [127:0] r;
      ch = iv;
      r  = '0;
      for (int i = 0; i < NB; i++) begin
         b = d[127-16*i -: 16];
         if (dec) begin
            o  = (b ^ k[15:0]) ^ ch;
            ch = b;
         end else begin
            o  = (b ^ ch) ^ k[15:0];
            ch = o;
         end
         if (i < nok) r[127-16*i -: 16] = o;
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input bit dec, input logic [127:0] d, input logic [19:0] k,
                       input logic [15:0] iv, input int nok);
      int w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_wait: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; in_decrypt = dec; in_data = d; in_key = k; in_iv = iv;
      sb.push_back('{cbc_model(dec, d, k, iv, nok), (nok < NB)});
      @(negedge clk);
      in_valid = 1'b0;
      // later input changes must not leak into the running message
      in_decrypt = ~dec;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = 20'($urandom);
      in_iv = 16'($urandom);
   endtask

   // Counts edges from acceptance until out_valid, and core_start pulses seen.
   task automatic wait_out(output int k, output int ns);
      k  = 0;
      ns = 0;
      while (!out_valid && k < 400) begin
         if (core_start) ns++;
         @(negedge clk);
         k++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b want 0", core_start); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL rst_out_error: got %b want 0", out_error); end
      checks++; if (core_key !== 20'h0 || core_block !== 16'h0) begin errors++; $display("FAIL rst_core_bus: got key %h blk %h want 0", core_key, core_block); end
      #1 rst_n = 1'b1;
      @(negedge clk);
      // out_ready without out_valid is ignored
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_ready: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_encrypt();
      int k, ns;
      exp_t e;
      send(1'b0, PT1, 20'h48FA2, 16'hA63E, NB);
      wait_out(k, ns);
      e = sb.pop_front();
      checks++; if (k !== 32) begin errors++; $display("FAIL enc_latency: got %0d edges want 32", k); end
      checks++; if (ns !== 8) begin errors++; $display("FAIL enc_starts: got %0d want 8", ns); end
      checks++; if (out_data !== ENC1) begin errors++; $display("FAIL enc_data: got %h want %h", out_data, ENC1); end
      checks++; if (out_error !== e.err) begin errors++; $display("FAIL enc_error: got %b want %b", out_error, e.err); end
      drain();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL enc_release: got out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_decrypt();
      int k, ns;
      exp_t e;
      send(1'b1, ENC1, 20'h48FA2, 16'hA63E, NB);
      wait_out(k, ns);
      e = sb.pop_front();
      checks++; if (out_data !== PT1) begin errors++; $display("FAIL dec_data: got %h want %h", out_data, PT1); end
      checks++; if (k !== 32 || out_error !== 1'b0) begin errors++; $display("FAIL dec_timing: got %0d edges err %b want 32 0", k, out_error); end
      drain();
      for (int i = 0; i < 4; i++) begin
         send(i[0], {$urandom, $urandom, $urandom, $urandom}, 20'($urandom), 16'($urandom), NB);
         wait_out(k, ns);
         e = sb.pop_front();
         checks++; if (out_data !== e.data || out_error !== e.err) begin errors++; $display("FAIL rand_%0d: got %h/%b want %h/%b", i, out_data, out_error, e.data, e.err); end
         checks++; if (k !== 32 || ns !== 8) begin errors++; $display("FAIL rand_timing_%0d: got %0d edges %0d starts want 32 8", i, k, ns); end
         drain();
      end
   endtask

   task automatic test_backpressure();
      int k, ns, bad;
      exp_t e;
      logic [127:0] nd;
      send(1'b0, {$urandom, $urandom, $urandom, $urandom}, 20'($urandom), 16'($urandom), NB);
      wait_out(k, ns);
      e  = sb.pop_front();
      nd = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_decrypt = 1'b1; in_data = nd; in_key = 20'h1234F; in_iv = 16'hBEEF;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || out_data !== e.data || out_error !== 1'b0 || in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
      sb.push_back('{cbc_model(1'b1, nd, 20'h1234F, 16'hBEEF, NB), 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
      wait_out(k, ns);
      e = sb.pop_front();
      checks++; if (out_data !== e.data || k !== 32) begin errors++; $display("FAIL b2b_data: got %h after %0d want %h after 32", out_data, k, e.data); end
      drain();
   endtask

   task automatic test_timeout();
      int guard, starts, n;
      exp_t e;
      stub_drop = stub_nstart + 2;
      send(1'b0, {$urandom, $urandom, $urandom, $urandom}, 20'($urandom), 16'($urandom), 2);
      starts = 0;
      guard = 0;
      while (guard < 100) begin
         if (core_start) starts++;
         if (starts == 3) break;
         @(negedge clk);
         guard++;
      end
      checks++; if (starts !== 3) begin errors++; $display("FAIL to_reach_blk2: got %0d starts want 3", starts); end
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      // 64 WAIT cycles follow the start cycle; out_valid is seen in the next one
      checks++; if (n !== 65) begin errors++; $display("FAIL to_cycles: got %0d want 65", n); end
      checks++; if (out_error !== 1'b1 || e.err !== 1'b1) begin errors++; $display("FAIL to_error: got %b want 1", out_error); end
      checks++; if (out_data !== e.data) begin errors++; $display("FAIL to_data: got %h want %h", out_data, e.data); end
      stub_drop = -1;
      drain();
      checks++; if (out_error !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL to_clear: got err %b valid %b want 0 0", out_error, out_valid); end
   endtask

   task automatic test_reset_midop();
      int guard, starts, k, ns, seen;
      exp_t e;
      send(1'b0, PT1, 20'h48FA2, 16'hA63E, NB);
      starts = 0;
      guard = 0;
      while (guard < 100) begin
         if (core_start) starts++;
         if (starts == 5) break;
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got in_ready %b busy %b want 1 0", in_ready, busy); end
      checks++; if (out_valid !== 1'b0 || core_start !== 1'b0 || out_error !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got valid %b start %b err %b want 0 0 0", out_valid, core_start, out_error); end
      checks++; if (out_data !== 128'h0 || core_block !== 16'h0 || core_key !== 20'h0) begin errors++; $display("FAIL mid_rst_data: got %h/%h/%h want 0", out_data, core_block, core_key); end
      e = sb.pop_back();
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_out: got %0d valid cycles want 0", seen); end
      send(1'b0, PT1, 20'h48FA2, 16'hA63E, NB);
      wait_out(k, ns);
      e = sb.pop_front();
      checks++; if (out_data !== ENC1 || out_error !== 1'b0 || k !== 32) begin errors++; $display("FAIL mid_rst_rerun: got %h/%b after %0d want %h/0 after 32", out_data, out_error, k, ENC1); end
      drain();
   endtask

   task automatic test_spurious();
      int k, ns;
      exp_t e;
      spur_res = 16'hFFFF;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL spur_idle_ctl: got ready %b busy %b valid %b start %b want 1 0 0 0", in_ready, busy, out_valid, core_start); end
      checks++; if (out_data !== ENC1) begin errors++; $display("FAIL spur_idle_data: got %h want %h", out_data, ENC1); end
      send(1'b1, {$urandom, $urandom, $urandom, $urandom}, 20'($urandom), 16'($urandom), NB);
      wait_out(k, ns);
      e = sb.pop_front();
      spur_res = 16'h5A5A;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== e.data || out_error !== 1'b0) begin errors++; $display("FAIL spur_done: got %b %h %b want 1 %h 0", out_valid, out_data, out_error, e.data); end
      drain();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL spur_exit: got valid %b ready %b want 0 1", out_valid, in_ready); end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_timeout();
      test_reset_midop();
      test_spurious();
      checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
